// File: rtl/i281_isa_pkg.sv
// i281 ISA constants shared by the instruction decode register and the control FSM.
package i281_isa_pkg;

  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_INPUT  = 4'h1;
  localparam logic [3:0] OP_MOVE   = 4'h2;
  localparam logic [3:0] OP_LOADI  = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_ADDI   = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_SUBI   = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_LOADF  = 4'h9;
  localparam logic [3:0] OP_STORE  = 4'hA;
  localparam logic [3:0] OP_STOREF = 4'hB;
  localparam logic [3:0] OP_SHIFT  = 4'hC;
  localparam logic [3:0] OP_CMP    = 4'hD;
  localparam logic [3:0] OP_JUMP   = 4'hE;
  localparam logic [3:0] OP_BRANCH = 4'hF;

  // One-hot bit positions; numbering matches the FSM's instruction list.
  localparam int IDX_NOOP    = 0;
  localparam int IDX_INPUTC  = 1;
  localparam int IDX_INPUTCF = 2;
  localparam int IDX_INPUTD  = 3;
  localparam int IDX_INPUTDF = 4;
  localparam int IDX_MOVE    = 5;
  localparam int IDX_LOADI   = 6;
  localparam int IDX_ADD     = 7;
  localparam int IDX_ADDI    = 8;
  localparam int IDX_SUB     = 9;
  localparam int IDX_SUBI    = 10;
  localparam int IDX_LOAD    = 11;
  localparam int IDX_LOADF   = 12;
  localparam int IDX_STORE   = 13;
  localparam int IDX_STOREF  = 14;
  localparam int IDX_SHIFTL  = 15;
  localparam int IDX_SHIFTR  = 16;
  localparam int IDX_CMP     = 17;
  localparam int IDX_JUMP    = 18;
  localparam int IDX_BRE     = 19;
  localparam int IDX_BRNE    = 20;
  localparam int IDX_BRG     = 21;
  localparam int IDX_BRGE    = 22;
  localparam int NUM_OPS     = 23;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 10;
  localparam int RY_MSB  = 9;
  localparam int RY_LSB  = 8;
  localparam int IMM_MSB = 7;

  localparam logic [26:0] OPCODE_NOOP = 27'h0000001;

endpackage

// File: rtl/i281_opcode_onehot.sv
// Combinational i281 instruction to one-hot opcode decoder with undefined sub-encoding detect.
module i281_opcode_onehot
  import i281_isa_pkg::*;
(
  input  logic [15:0]         instr,
  output logic [NUM_OPS-1:0]  onehot,
  output logic                illegal_enc
);

  logic [3:0] op;
  logic [1:0] ry;

  assign op = instr[OP_MSB:OP_LSB];
  assign ry = instr[RY_MSB:RY_LSB];

  always_comb begin
    onehot      = '0;
    illegal_enc = 1'b0;
    case (op)
      OP_NOOP:   onehot[IDX_NOOP]   = 1'b1;
      OP_INPUT:  onehot[IDX_INPUTC + int'(ry)] = 1'b1;
      OP_MOVE:   onehot[IDX_MOVE]   = 1'b1;
      OP_LOADI:  onehot[IDX_LOADI]  = 1'b1;
      OP_ADD:    onehot[IDX_ADD]    = 1'b1;
      OP_ADDI:   onehot[IDX_ADDI]   = 1'b1;
      OP_SUB:    onehot[IDX_SUB]    = 1'b1;
      OP_SUBI:   onehot[IDX_SUBI]   = 1'b1;
      OP_LOAD:   onehot[IDX_LOAD]   = 1'b1;
      OP_LOADF:  onehot[IDX_LOADF]  = 1'b1;
      OP_STORE:  onehot[IDX_STORE]  = 1'b1;
      OP_STOREF: onehot[IDX_STOREF] = 1'b1;
      OP_SHIFT: begin
        // RY 1x has no defined shift; fall back to NOOP so the one-hot stays valid.
        if (ry[1]) begin
          onehot[IDX_NOOP] = 1'b1;
          illegal_enc      = 1'b1;
        end else begin
          onehot[IDX_SHIFTL + int'(ry[0])] = 1'b1;
        end
      end
      OP_CMP:    onehot[IDX_CMP]    = 1'b1;
      OP_JUMP:   onehot[IDX_JUMP]   = 1'b1;
      default:   onehot[IDX_BRE + int'(ry)] = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_decode_register.sv
// i281 instruction register with registered one-hot decode, instruction counter and sticky illegal flag.
module instruction_decode_register
  import i281_isa_pkg::*;
#(
  parameter int IW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IW-1:0]    instr_in,
  input  logic             ir_load,
  input  logic             flush,
  output logic [26:0]      opcode_out,
  output logic [7:0]       imm_out,
  output logic [IW-1:0]    ir_out,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  logic [NUM_OPS-1:0] onehot;
  logic               illegal_enc;

  i281_opcode_onehot u_dec (
    .instr       (instr_in[15:0]),
    .onehot      (onehot),
    .illegal_enc (illegal_enc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_out      <= '0;
      opcode_out  <= OPCODE_NOOP;
      imm_out     <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else if (flush) begin
      ir_out     <= '0;
      opcode_out <= OPCODE_NOOP;
      imm_out    <= '0;
    end else if (ir_load) begin
      ir_out     <= instr_in;
      opcode_out <= {instr_in[RX_MSB:RX_LSB], instr_in[RY_MSB:RY_LSB], onehot};
      imm_out    <= instr_in[IMM_MSB:0];
      if (instr_count != {CNT_W{1'b1}})
        instr_count <= instr_count + 1'b1;
      if (illegal_enc)
        illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_decode_register.sv
// Directed self-checking bench for instruction_decode_register (full-width and 4-bit-counter instances).
module tb_instruction_decode_register;

  logic        clock = 1'b0;
  logic        reset, ir_load, flush;
  logic [15:0] instr_in;
  logic [26:0] opcode_out;
  logic [7:0]  imm_out;
  logic [15:0] ir_out;
  logic [15:0] instr_count;
  logic        illegal;

  logic        s_reset, s_load, s_flush;
  logic [15:0] s_instr;
  logic [26:0] s_opcode;
  logic [7:0]  s_imm;
  logic [15:0] s_ir;
  logic [3:0]  s_count;
  logic        s_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  instruction_decode_register #(.IW(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .ir_load(ir_load), .flush(flush),
    .opcode_out(opcode_out), .imm_out(imm_out), .ir_out(ir_out),
    .instr_count(instr_count), .illegal(illegal)
  );

  instruction_decode_register #(.IW(16), .CNT_W(4)) dut_small (
    .clock(clock), .reset(s_reset), .instr_in(s_instr), .ir_load(s_load), .flush(s_flush),
    .opcode_out(s_opcode), .imm_out(s_imm), .ir_out(s_ir),
    .instr_count(s_count), .illegal(s_illegal)
  );

  // Expected one-hot index for every op/RY pair, from the ISA table; -1 marks undefined.
  function automatic int exp_idx(input logic [3:0] op, input logic [1:0] ry);
    case (op)
      4'h0: return 0;
      4'h1: return (ry == 2'd0) ? 1 : (ry == 2'd1) ? 2 : (ry == 2'd2) ? 3 : 4;
      4'h2: return 5;
      4'h3: return 6;
      4'h4: return 7;
      4'h5: return 8;
      4'h6: return 9;
      4'h7: return 10;
      4'h8: return 11;
      4'h9: return 12;
      4'hA: return 13;
      4'hB: return 14;
      4'hC: return (ry == 2'd0) ? 15 : (ry == 2'd1) ? 16 : -1;
      4'hD: return 17;
      4'hE: return 18;
      default: return (ry == 2'd0) ? 19 : (ry == 2'd1) ? 20 : (ry == 2'd2) ? 21 : 22;
    endcase
  endfunction

  // Apply one clock edge with the given controls, then sample 1 time unit after the edge.
  task automatic cycle(input logic rst, input logic ld, input logic fl, input logic [15:0] w);
    reset = rst; ir_load = ld; flush = fl; instr_in = w;
    @(posedge clock);
    #1;
    reset = 1'b0; ir_load = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    s_reset = 1'b1; s_load = 1'b0; s_flush = 1'b0; s_instr = '0;
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b1, 16'h4E00);
    s_reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    checks++; if (opcode_out !== 27'h0000001) begin errors++; $display("FAIL reset_opcode got %h want %h", opcode_out, 27'h0000001); end
    checks++; if (ir_out !== 16'h0) begin errors++; $display("FAIL reset_ir got %h want 0000", ir_out); end
    checks++; if (imm_out !== 8'h0) begin errors++; $display("FAIL reset_imm got %h want 00", imm_out); end
    checks++; if (instr_count !== 16'h0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_count); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
  endtask

  task automatic test_add();
    cycle(1'b0, 1'b1, 1'b0, 16'h4E00);
    checks++; if (opcode_out !== 27'h7000080) begin errors++; $display("FAIL add_opcode got %h want %h", opcode_out, 27'h7000080); end
    checks++; if (ir_out !== 16'h4E00) begin errors++; $display("FAIL add_ir got %h want 4e00", ir_out); end
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL add_count got %0d want 1", instr_count); end
    cycle(1'b0, 1'b0, 1'b0, 16'hFFFF);
    checks++; if (opcode_out !== 27'h7000080 || ir_out !== 16'h4E00 || instr_count !== 16'd1) begin
      errors++; $display("FAIL idle_hold got op=%h ir=%h cnt=%0d want op=7000080 ir=4e00 cnt=1", opcode_out, ir_out, instr_count);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] w;
    logic [26:0] exp_op;
    logic        exp_ill;
    int          idx;
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    exp_ill = 1'b0;
    for (int op = 0; op < 16; op++) begin
      for (int ry = 0; ry < 4; ry++) begin
        w = {op[3:0], op[1:0], ry[1:0], op[3:0], ry[1:0], 2'b01};
        idx = exp_idx(op[3:0], ry[1:0]);
        if (idx < 0) begin
          exp_ill = 1'b1;
          idx = 0;
        end
        exp_op = {op[1:0], ry[1:0], 23'd0};
        exp_op[idx] = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, w);
        checks++; if (opcode_out !== exp_op) begin errors++; $display("FAIL sweep_opcode w=%h got %h want %h", w, opcode_out, exp_op); end
        checks++; if (imm_out !== w[7:0] || ir_out !== w) begin errors++; $display("FAIL sweep_fields w=%h got ir=%h imm=%h", w, ir_out, imm_out); end
        checks++; if (illegal !== exp_ill) begin errors++; $display("FAIL sweep_illegal w=%h got %b want %b", w, illegal, exp_ill); end
      end
    end
    checks++; if (instr_count !== 16'd64) begin errors++; $display("FAIL sweep_count got %0d want 64", instr_count); end
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b1, 1'b1, 16'hF3A5);
    checks++; if (opcode_out !== 27'h0000001) begin errors++; $display("FAIL flush_opcode got %h want 0000001", opcode_out); end
    checks++; if (ir_out !== 16'h0 || imm_out !== 8'h0) begin errors++; $display("FAIL flush_ir got ir=%h imm=%h want 0000/00", ir_out, imm_out); end
    checks++; if (instr_count !== 16'd64) begin errors++; $display("FAIL flush_count got %0d want 64", instr_count); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL flush_illegal got %b want 1", illegal); end
    cycle(1'b0, 1'b1, 1'b0, 16'hF3A5);
    checks++; if (opcode_out !== 27'h1C00000) begin errors++; $display("FAIL brge_opcode got %h want 1c00000", opcode_out); end
    checks++; if (imm_out !== 8'hA5) begin errors++; $display("FAIL brge_imm got %h want a5", imm_out); end
    checks++; if (instr_count !== 16'd65) begin errors++; $display("FAIL brge_count got %0d want 65", instr_count); end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 1'b0, 16'h2600);
    checks++; if (opcode_out !== 27'h3000020) begin errors++; $display("FAIL b2b_move got %h want 3000020", opcode_out); end
    cycle(1'b0, 1'b1, 1'b0, 16'hC100);
    checks++; if (opcode_out !== 27'h0810000) begin errors++; $display("FAIL b2b_shiftr got %h want 0810000", opcode_out); end
    cycle(1'b0, 1'b1, 1'b0, 16'hE0FF);
    checks++; if (opcode_out !== 27'h0040000 || imm_out !== 8'hFF) begin errors++; $display("FAIL b2b_jump got %h imm %h want 0040000 ff", opcode_out, imm_out); end
    checks++; if (instr_count !== 16'd68) begin errors++; $display("FAIL b2b_count got %0d want 68", instr_count); end
  endtask

  task automatic test_saturation();
    s_load = 1'b1; s_instr = 16'h4E00;
    for (int i = 0; i < 14; i++) @(posedge clock);
    #1;
    checks++; if (s_count !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", s_count); end
    @(posedge clock); #1;
    checks++; if (s_count !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d want 15", s_count); end
    @(posedge clock); #1;
    @(posedge clock); #1;
    s_load = 1'b0;
    checks++; if (s_count !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", s_count); end
    checks++; if (s_opcode !== 27'h7000080) begin errors++; $display("FAIL sat_opcode got %h want 7000080", s_opcode); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 1'b0, 16'h9123);
    checks++; if (opcode_out !== 27'h0801000 || imm_out !== 8'h23) begin errors++; $display("FAIL loadf_opcode got %h imm %h want 0801000 23", opcode_out, imm_out); end
    cycle(1'b1, 1'b1, 1'b0, 16'h4E00);
    checks++; if (opcode_out !== 27'h0000001 || ir_out !== 16'h0 || imm_out !== 8'h0) begin
      errors++; $display("FAIL midreset_regs got op=%h ir=%h imm=%h want 0000001/0000/00", opcode_out, ir_out, imm_out);
    end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", instr_count); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL midreset_illegal got %b want 0", illegal); end
  endtask

  initial begin
    reset = 1'b1; ir_load = 1'b0; flush = 1'b0; instr_in = '0;
    test_reset();
    test_add();
    test_sweep();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_register.md
# instruction_decode_register

Instruction register and registered opcode decoder for the i281 multicycle CPU; the producing end of the 27-bit opcode bus consumed by the control FSM. It captures a 16-bit word from instruction memory when the FSM asserts the IR-load control, decodes it into the one-hot opcode plus RX/RY fields, and holds them stable for the ID, Ex, Mem and Wb states. It also exposes the raw IR and immediate to the datapath, and keeps an instruction counter and a sticky illegal-encoding flag for debug.

## Interface
- IW, 16: instruction width; fixed for i281, no other value supported.
- CNT_W, 16: width of the instruction counter.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- instr_in  in  IW  instruction word from IMEM, sampled when ir_load=1.
- ir_load  in  1  capture strobe (FSM IF-state load control).
- flush  in  1  replace held instruction with NOOP.
- opcode_out  out  27  [26:25]=RX, [24:23]=RY, [22:0]=one-hot opcode.
- imm_out  out  8  IR[7:0].
- ir_out  out  IW  raw held instruction.
- instr_count  out  CNT_W  number of accepted loads, saturating.
- illegal  out  1  sticky; set by an undefined sub-encoding.

## Operation
- Fields: op=IR[15:12], RX=IR[11:10], RY=IR[9:8], imm=IR[7:0].
- One-hot bit index per op:
  - 0000 NOOP→0.
  - 0001 INPUT: RY 00/01/10/11 → INPUTC 1, INPUTCF 2, INPUTD 3, INPUTDF 4.
  - 0010 MOVE→5; 0011 LOADI/LOADP→6.
  - 0100 ADD→7; 0101 ADDI→8; 0110 SUB→9; 0111 SUBI→10.
  - 1000 LOAD→11; 1001 LOADF→12; 1010 STORE→13; 1011 STOREF→14.
  - 1100 SHIFT: RY 00→SHIFTL 15, RY 01→SHIFTR 16, RY 1x→illegal.
  - 1101 CMP→17; 1110 JUMP→18.
  - 1111 BRANCH: RY 00/01/10/11 → BRE 19, BRNE 20, BRG 21, BRGE 22.
- Illegal encoding:
  - opcode_out[22:0] = NOOP one-hot.
  - RX/RY fields still passed through.
  - ir_out holds the raw word.
  - illegal set to 1 until reset.
- Exactly one bit of opcode_out[22:0] is high at all times, including after reset.
- RX/RY are passed raw; the register-port swap for MOVE/LOADF/STORE/STOREF belongs to the FSM, not here.
- flush:
  - ir_out←0, opcode_out←{4'b0, NOOP one-hot}, imm_out←0.
  - Counter and illegal unchanged.
- ir_load without flush:
  - Load ir_out, opcode_out and imm_out from instr_in.
  - instr_count +1, saturating at 2^CNT_W−1.
- ir_load and flush together: flush wins; count not incremented.
- Neither: all outputs hold.

## Timing
- All outputs are registered; no combinational path from instr_in/ir_load/flush to any output.
- Latency 1: a word presented with ir_load at edge N appears decoded on all outputs after edge N, ready for the FSM ID state in the next cycle.
- Consecutive ir_load cycles are legal; each loads and counts.
- Reset values: ir_out=0, opcode_out=27'h0000001 (NOOP), imm_out=0, instr_count=0, illegal=0.
- reset dominates ir_load and flush in the same cycle.
- Reset mid-instruction discards the held instruction without counting it.
- Illegal flag sets on the same edge that loads the illegal word.

## Structure
- Package i281_isa_pkg:
  - 4-bit op constants (OP_NOOP…OP_BRANCH).
  - One-hot index constants 0–22, matching the FSM's instruction numbering.
  - Field bit-position constants and the 27-bit NOOP constant.
  - The FSM is migrated to import the same package.
- Sub-module i281_opcode_onehot: purely combinational, instr[15:0] → {onehot[22:0], illegal_enc}. The top-level holds the registers, flush/load priority and saturating counter.

## Test plan
- Reset then idle → opcode_out=27'h0000001, ir_out=0, instr_count=0, illegal=0.
- ir_load with 16'h4E00 (ADD RX=3,RY=2) → next cycle opcode_out[26:25]=3, [24:23]=2, bit 7 only; instr_count=1.
- Sweep all 16 ops × 4 RY values with ir_load → one-hot index per the table. SHIFT RY=10/11 gives NOOP and illegal=1 sticky through later legal loads; instr_count=64.
- ir_load with 16'hF3A5 (BRGE) and flush in the same cycle → opcode_out=NOOP, ir_out=0, count unchanged. Next cycle ir_load 16'hF3A5 → bit 22, imm_out=8'hA5.
- Preload instr_count to 16'hFFFF (CNT_W reduced to 4 in a parameter run, 15 loads), then ir_load → count stays at max.
- Assert reset in the cycle after loading 16'h9123 (LOADF) → all outputs return to reset values in the next cycle, illegal cleared.
